// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch sequencer.
// Holds the FSM state encoding, PC mux selects and PC constants.
package fetch_pkg;

    localparam logic [7:0] DEF_RESET_PC = 8'h00;
    localparam int         DEF_STEP     = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PC_HOLD   = 2'd0,
        PC_LOAD   = 2'd1,
        PC_STEP   = 2'd2,
        PC_BRANCH = 2'd3
    } pc_sel_t;

    // 8-bit add; the carry out is dropped so the PC wraps modulo 256.
    function automatic logic [7:0] pc_add(
        input logic [7:0] base,
        input logic [7:0] inc
    );
        return base + inc;
    endfunction

endpackage

// File: rtl/fetch_sequencer_pc_reg.sv
// Program counter register with load / step / branch next-PC mux.
// Ports: clk, rst (async, active-high), sel, load_addr, branch_target, pc.
module pc_reg
    import fetch_pkg::*;
#(
    parameter logic [7:0] RESET_PC = DEF_RESET_PC,
    parameter int         STEP     = DEF_STEP
) (
    input  logic       clk,
    input  logic       rst,
    input  pc_sel_t    sel,
    input  logic [7:0] load_addr,
    input  logic [7:0] branch_target,
    output logic [7:0] pc
);

    localparam logic [7:0] STEP8 = 8'(STEP);

    logic [7:0] pc_next;

    always_comb begin
        pc_next = pc;
        case (sel)
            PC_LOAD:   pc_next = load_addr;
            PC_STEP:   pc_next = pc_add(pc, STEP8);
            PC_BRANCH: pc_next = branch_target;
            default:   pc_next = pc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: IDLE -> FETCH -> ISSUE loop with
// branch redirect, halt and absolute PC load.
// Ports: clk, rst_n (async, active-high), start, halt, load_en/load_addr,
//   branch_valid/branch_target, mem_ready/mem_rdata, instr_ready in;
//   mem_req, mem_addr, instr_valid, instr_out, pc, busy out.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [7:0] RESET_PC = DEF_RESET_PC,
    parameter int         STEP     = DEF_STEP
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       halt,
    input  logic       load_en,
    input  logic [7:0] load_addr,
    input  logic       branch_valid,
    input  logic [7:0] branch_target,
    input  logic       mem_ready,
    input  logic [7:0] mem_rdata,
    input  logic       instr_ready,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    output logic       instr_valid,
    output logic [7:0] instr_out,
    output logic [7:0] pc,
    output logic       busy
);

    state_t  state;
    state_t  state_next;
    pc_sel_t pc_sel;
    logic    capture;

    // State register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; halt overrides everything.
    always_comb begin
        state_next = state;
        if (halt) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!load_en && start) begin
                        state_next = S_FETCH;
                    end
                end
                S_FETCH: begin
                    // A redirect restarts the fetch at the new PC.
                    if (!branch_valid && mem_ready) begin
                        state_next = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (instr_ready) begin
                        state_next = S_FETCH;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Outputs decoded from state only, so reset clears them at once.
    always_comb begin
        mem_req     = (state == S_FETCH);
        instr_valid = (state == S_ISSUE);
        busy        = (state != S_IDLE);
    end

    // PC mux select.
    always_comb begin
        pc_sel = PC_HOLD;
        if (!halt) begin
            case (state)
                S_IDLE: begin
                    if (load_en) begin
                        pc_sel = PC_LOAD;
                    end
                end
                S_FETCH: begin
                    if (branch_valid) begin
                        pc_sel = PC_BRANCH;
                    end
                end
                S_ISSUE: begin
                    if (instr_ready) begin
                        pc_sel = branch_valid ? PC_BRANCH : PC_STEP;
                    end
                end
                default: pc_sel = PC_HOLD;
            endcase
        end
    end

    // Read data is taken only when the fetch is neither redirected
    // nor abandoned by halt.
    assign capture = (state == S_FETCH) && mem_ready
                     && !branch_valid && !halt;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            instr_out <= 8'h00;
        end else if (capture) begin
            instr_out <= mem_rdata;
        end
    end

    pc_reg #(
        .RESET_PC (RESET_PC),
        .STEP     (STEP)
    ) u_pc_reg (
        .clk           (clk),
        .rst           (rst_n),
        .sel           (pc_sel),
        .load_addr     (load_addr),
        .branch_target (branch_target),
        .pc            (pc)
    );

    assign mem_addr = pc;

endmodule
